cdb_arbiter: RTL

- Shares the single common data bus (CDB) between NUM_UNITS functional units. Each unit presents one completed result; the ROB and the reservation stations snoop the result.
- Round-robin arbitration picks one requester per cycle and returns a one-cycle grant. The winner's payload is registered onto the CDB one cycle later.
- Sits between the execution units and the cdb_if consumers: reorder_buffer and the reservation stations.

---
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single common data bus (CDB) between NUM_UNITS functional units.
//   A round-robin search starting at rr_ptr picks one requester per cycle and
//   returns a combinational one-hot grant. The winner's payload is registered
//   onto the CDB and is visible for exactly one cycle after the grant edge.
//
// Ports
//   clk            clock
//   n_rst          synchronous active-high reset (1 = reset)
//   i_flush        pipeline flush: suppresses grant, clears broadcast, rr_ptr->0
//   i_req          per-unit result-valid request
//   i_data         per-unit result data, unit k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_addr         per-unit redirect address
//   i_tag          per-unit ROB tag
//   i_redirect     per-unit mispredict/redirect flag
//   o_gnt          one-hot grant (combinational)
//   o_cdb_en       broadcast valid
//   o_cdb_data     broadcast data
//   o_cdb_addr     broadcast redirect address
//   o_cdb_tag      broadcast ROB tag
//   o_cdb_redirect broadcast redirect flag
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            i_flush,
    input  logic [NUM_UNITS-1:0]            i_req,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_UNITS*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_UNITS*TAG_WIDTH-1:0]  i_tag,
    input  logic [NUM_UNITS-1:0]            i_redirect,
    output logic [NUM_UNITS-1:0]            o_gnt,
    output logic                            o_cdb_en,
    output logic [DATA_WIDTH-1:0]           o_cdb_data,
    output logic [ADDR_WIDTH-1:0]           o_cdb_addr,
    output logic [TAG_WIDTH-1:0]            o_cdb_tag,
    output logic                            o_cdb_redirect
);

    localparam int                   PTR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_UNITS - 1);
    localparam logic [NUM_UNITS-1:0] GNT_LSB  = NUM_UNITS'(1);

    // Round-robin pick: returns {found, index} of the first set request
    // found when scanning upwards from ptr with wrap-around.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_UNITS-1:0] req,
                                               input logic [PTR_W-1:0]     ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] idx_w;
        int               idx;
        res = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx   = (int'(ptr) + i) % NUM_UNITS;
            idx_w = idx[PTR_W-1:0];
            res   = (req[idx_w] && !res[PTR_W]) ? {1'b1, idx_w} : res;
        end
        return res;
    endfunction

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  cdb_en_q, cdb_en_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [ADDR_WIDTH-1:0] cdb_addr_q, cdb_addr_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic                  cdb_redirect_q, cdb_redirect_d;

    logic [PTR_W:0]        pick_s;
    logic [PTR_W-1:0]      gnt_idx_s;
    logic                  gnt_vld_s;
    logic [NUM_UNITS-1:0]  gnt_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [TAG_WIDTH-1:0]  sel_tag_s;
    logic                  sel_redirect_s;

    // Arbitration: reset and flush both mask the grant.
    always_comb begin
        pick_s    = rr_pick(i_req, rr_ptr_q);
        gnt_idx_s = pick_s[PTR_W-1:0];
        gnt_vld_s = pick_s[PTR_W] & ~i_flush & ~n_rst;
        if (gnt_vld_s) begin
            gnt_s = GNT_LSB << gnt_idx_s;
        end else begin
            gnt_s = '0;
        end
    end

    // Winner payload select as a one-hot AND-OR mux over the grant vector.
    always_comb begin
        sel_data_s     = '0;
        sel_addr_s     = '0;
        sel_tag_s      = '0;
        sel_redirect_s = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sel_data_s     = sel_data_s | ({DATA_WIDTH{gnt_s[k]}} & i_data[k*DATA_WIDTH +: DATA_WIDTH]);
            sel_addr_s     = sel_addr_s | ({ADDR_WIDTH{gnt_s[k]}} & i_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
            sel_tag_s      = sel_tag_s  | ({TAG_WIDTH{gnt_s[k]}}  & i_tag[k*TAG_WIDTH +: TAG_WIDTH]);
            sel_redirect_s = sel_redirect_s | (gnt_s[k] & i_redirect[k]);
        end
    end

    // Next-state: pointer advance past the winner and broadcast capture.
    // Payload registers hold when idle so consumers see stable (don't-care) values.
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        cdb_en_d       = 1'b0;
        cdb_data_d     = cdb_data_q;
        cdb_addr_d     = cdb_addr_q;
        cdb_tag_d      = cdb_tag_q;
        cdb_redirect_d = cdb_redirect_q;
        if (i_flush) begin
            rr_ptr_d = '0;
        end else if (gnt_vld_s) begin
            rr_ptr_d       = (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + PTR_W'(1);
            cdb_en_d       = 1'b1;
            cdb_data_d     = sel_data_s;
            cdb_addr_d     = sel_addr_s;
            cdb_tag_d      = sel_tag_s;
            cdb_redirect_d = sel_redirect_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            rr_ptr_q       <= '0;
            cdb_en_q       <= 1'b0;
            cdb_data_q     <= '0;
            cdb_addr_q     <= '0;
            cdb_tag_q      <= '0;
            cdb_redirect_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            cdb_en_q       <= cdb_en_d;
            cdb_data_q     <= cdb_data_d;
            cdb_addr_q     <= cdb_addr_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_redirect_q <= cdb_redirect_d;
        end
    end

    assign o_gnt          = gnt_s;
    assign o_cdb_en       = cdb_en_q;
    assign o_cdb_data     = cdb_data_q;
    assign o_cdb_addr     = cdb_addr_q;
    assign o_cdb_tag      = cdb_tag_q;
    assign o_cdb_redirect = cdb_redirect_q;

endmodule
